snpu_deck_ctrl: RTL and testbench

Command-driven sequencer for the SNPU policy deck: owns the 17-card policy register (6 liberal = 0, 11 fascist = 1), the stack/hand/discard/board bookkeeping, and the LFSR-driven shuffle. Sits between the host pin decoder in `tt_um_SNPU` and the deck state. It accepts one opcode at a time over a valid/ready handshake and answers with a one-cycle response pulse.

---
 rtl/snpu_pkg.sv | 25 ++
 rtl/snpu_lfsr16.sv | 26 ++
 rtl/snpu_deck_ctrl.sv | 205 ++++++++++++++++++++
 tb/tb_snpu_deck_ctrl.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/snpu_pkg.sv
// Shared opcodes, deck constants and controller state encoding for the SNPU policy deck.
package snpu_pkg;

  localparam int          DECK_SIZE = 17;
  localparam logic [16:0] DECK_INIT = 17'h1FFC0;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  localparam logic [2:0] OP_NOP        = 3'd0;
  localparam logic [2:0] OP_DECK_RESET = 3'd1;
  localparam logic [2:0] OP_SHUFFLE    = 3'd2;
  localparam logic [2:0] OP_DRAW       = 3'd3;
  localparam logic [2:0] OP_PEEK       = 3'd4;
  localparam logic [2:0] OP_DISCARD    = 3'd5;
  localparam logic [2:0] OP_PLAY       = 3'd6;
  localparam logic [2:0] OP_BOARD      = 3'd7;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_MERGE = 3'd1,
    ST_FY    = 3'd2,
    ST_DRAW  = 3'd3,
    ST_RESP  = 3'd4
  } state_t;

endpackage

// File: rtl/snpu_lfsr16.sv
// Free-running 16-bit Galois LFSR; a load overrides the advance for one cycle.
module snpu_lfsr16
  import snpu_pkg::*;
#(
  parameter logic [15:0] RESET_VAL = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic [15:0] load_val,
  output logic [15:0] out
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out <= RESET_VAL;
    end else if (load) begin
      out <= load_val;
    end else if (out[0]) begin
      out <= (out >> 1) ^ LFSR_TAPS;
    end else begin
      out <= out >> 1;
    end
  end

endmodule

// File: rtl/snpu_deck_ctrl.sv
// Policy deck sequencer: one command at a time, answered by a one-cycle response pulse.
// Handshake: a command is taken on the edge where cmd_valid && cmd_ready; cmd_ready stays low until the rsp_valid cycle has passed, and rsp_valid has no backpressure.
module snpu_deck_ctrl
  import snpu_pkg::*;
#(
  parameter logic [15:0] SEED_DEFAULT = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [2:0]  cmd_op,
  input  logic [1:0]  cmd_arg,
  input  logic [15:0] seed,
  output logic        rsp_valid,
  output logic        rsp_err,
  output logic [7:0]  rsp_data,
  output logic [4:0]  n_stack,
  output logic [4:0]  n_discard,
  output logic [1:0]  n_hand,
  output logic [2:0]  board_lib,
  output logic [3:0]  board_fas,
  output state_t      dbg_state
);

  state_t      state, state_nxt;
  logic [16:0] deck;
  logic [2:0]  hand;
  logic [4:0]  ns, nd, fy_i;
  logic [1:0]  nh;
  logic [2:0]  blib;
  logic [3:0]  bfas;
  logic        draw_pend, err_q;
  logic [7:0]  data_q;

  logic [15:0] lfsr, lfsr_load_val;
  logic [4:0]  r;
  logic        lfsr_load, lfsr_unused;
  logic        accept, cmd_err, fy_hit, merge_done;

  snpu_lfsr16 #(.RESET_VAL(SEED_DEFAULT)) u_lfsr (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (lfsr_load),
    .load_val (lfsr_load_val),
    .out      (lfsr)
  );

  assign r           = lfsr[4:0];
  assign lfsr_unused = ^lfsr[15:5];

  always_comb begin
    accept  = cmd_valid && (state == ST_IDLE);
    cmd_err = 1'b0;
    case (cmd_op)
      OP_SHUFFLE:          cmd_err = (nh != 2'd0);
      OP_DRAW:             cmd_err = (nh != 2'd0) || ((ns + nd) < 5'd3);
      OP_PEEK, OP_DISCARD: cmd_err = (cmd_arg >= nh);
      OP_PLAY:             cmd_err = (nh != 2'd1);
      default:             cmd_err = 1'b0;
    endcase
    lfsr_load     = accept && (cmd_op == OP_DECK_RESET);
    lfsr_load_val = (seed != 16'd0) ? seed : SEED_DEFAULT;
    fy_hit        = (r <= fy_i);
    merge_done    = (nd == 5'd0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          if (cmd_err)
            state_nxt = ST_RESP;
          else if ((cmd_op == OP_SHUFFLE) || ((cmd_op == OP_DRAW) && (ns < 5'd3)))
            state_nxt = ST_MERGE;
          else
            state_nxt = ST_RESP;
        end
      end
      ST_MERGE: begin
        if (merge_done) begin
          if (ns > 5'd1) state_nxt = ST_FY;
          else           state_nxt = draw_pend ? ST_DRAW : ST_RESP;
        end
      end
      // The swap at i==1 is the last one, so leave on that edge.
      ST_FY: begin
        if (fy_hit && (fy_i == 5'd1)) state_nxt = draw_pend ? ST_DRAW : ST_RESP;
      end
      ST_DRAW: state_nxt = ST_RESP;
      ST_RESP: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      deck      <= DECK_INIT;
      hand      <= '0;
      ns        <= 5'(DECK_SIZE);
      nd        <= '0;
      nh        <= '0;
      blib      <= '0;
      bfas      <= '0;
      fy_i      <= '0;
      draw_pend <= 1'b0;
      err_q     <= 1'b0;
      data_q    <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            err_q     <= cmd_err;
            data_q    <= '0;
            draw_pend <= 1'b0;
            if (!cmd_err) begin
              case (cmd_op)
                OP_NOP: ;
                OP_DECK_RESET: begin
                  deck <= DECK_INIT;
                  hand <= '0;
                  ns   <= 5'(DECK_SIZE);
                  nd   <= '0;
                  nh   <= '0;
                  blib <= '0;
                  bfas <= '0;
                end
                OP_SHUFFLE: ;
                OP_DRAW: begin
                  if (ns < 5'd3) begin
                    draw_pend <= 1'b1;
                  end else begin
                    hand <= {deck[ns - 5'd3], deck[ns - 5'd2], deck[ns - 5'd1]};
                    ns   <= ns - 5'd3;
                    nh   <= 2'd3;
                  end
                end
                OP_PEEK: data_q <= {7'd0, hand[cmd_arg]};
                OP_DISCARD: begin
                  deck[5'd16 - nd] <= hand[cmd_arg];
                  nd <= nd + 5'd1;
                  nh <= nh - 2'd1;
                  case (cmd_arg)
                    2'd0:    hand <= {1'b0, hand[2:1]};
                    2'd1:    hand <= {1'b0, hand[2], hand[0]};
                    default: hand <= {1'b0, hand[1:0]};
                  endcase
                end
                OP_PLAY: begin
                  if (hand[0]) bfas <= bfas + 4'd1;
                  else         blib <= blib + 3'd1;
                  nh     <= '0;
                  data_q <= {7'd0, hand[0]};
                end
                OP_BOARD: data_q <= {bfas, 1'b0, blib};
                default: ;
              endcase
            end
          end
        end
        // Discard sits packed at the top of the array, so its lowest card is deck[17-nd].
        ST_MERGE: begin
          if (!merge_done) begin
            deck[ns] <= deck[5'd17 - nd];
            ns       <= ns + 5'd1;
            nd       <= nd - 5'd1;
          end else begin
            fy_i <= ns - 5'd1;
          end
        end
        ST_FY: begin
          if (fy_hit) begin
            deck[fy_i] <= deck[r];
            deck[r]    <= deck[fy_i];
            fy_i       <= fy_i - 5'd1;
          end
        end
        ST_DRAW: begin
          hand <= {deck[ns - 5'd3], deck[ns - 5'd2], deck[ns - 5'd1]};
          ns   <= ns - 5'd3;
          nh   <= 2'd3;
        end
        default: ;
      endcase
    end
  end

  assign cmd_ready = (state == ST_IDLE);
  assign rsp_valid = (state == ST_RESP);
  assign rsp_err   = rsp_valid & err_q;
  assign rsp_data  = rsp_valid ? data_q : 8'd0;
  assign n_stack   = ns;
  assign n_discard = nd;
  assign n_hand    = nh;
  assign board_lib = blib;
  assign board_fas = bfas;
  assign dbg_state = state;

endmodule

// File: tb/tb_snpu_deck_ctrl.sv
// Directed bench for snpu_deck_ctrl: stimulus pushes expected responses, a monitor pops and compares.
module tb_snpu_deck_ctrl;
  import snpu_pkg::*;

  localparam int RW = 28;
  localparam logic [RW-1:0] M_FULL  = {RW{1'b1}};
  localparam logic [RW-1:0] M_BRD   = {1'b1, 8'hFF, 5'h1F, 5'h1F, 2'h3, 3'h0, 4'h0};
  localparam logic [RW-1:0] M_D0BRD = {1'b1, 8'hFE, 5'h1F, 5'h1F, 2'h3, 3'h0, 4'h0};

  logic        clk, rst_n, cmd_valid, cmd_ready, rsp_valid, rsp_err;
  logic [2:0]  cmd_op, board_lib;
  logic [1:0]  cmd_arg, n_hand;
  logic [15:0] seed;
  logic [7:0]  rsp_data, last_data;
  logic [4:0]  n_stack, n_discard;
  logic [3:0]  board_fas;
  state_t      dbg_state;

  logic [RW-1:0] exp_q[$];
  logic [RW-1:0] msk_q[$];
  logic [RW-1:0] mon_act, mon_exp, mon_msk;
  int n_checks = 0, n_fail = 0, rsp_cnt = 0;
  int e_ns, e_nd, e_nh, ones, lat, w;

  snpu_deck_ctrl dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_arg(cmd_arg), .seed(seed), .rsp_valid(rsp_valid),
    .rsp_err(rsp_err), .rsp_data(rsp_data), .n_stack(n_stack), .n_discard(n_discard),
    .n_hand(n_hand), .board_lib(board_lib), .board_fas(board_fas), .dbg_state(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  function automatic logic [RW-1:0] pk(input logic e, input logic [7:0] d, input logic [4:0] s,
                                       input logic [4:0] di, input logic [1:0] h,
                                       input logic [2:0] bl, input logic [3:0] bf);
    return {e, d, s, di, h, bl, bf};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    if (rst_n && rsp_valid) begin
      mon_act   = {rsp_err, rsp_data, n_stack, n_discard, n_hand, board_lib, board_fas};
      last_data = rsp_data;
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_rsp: got %h expected no response", mon_act);
      end else begin
        mon_exp = exp_q.pop_front();
        mon_msk = msk_q.pop_front();
        if ((mon_act & mon_msk) !== (mon_exp & mon_msk)) begin
          n_fail++;
          $display("FAIL rsp_%0d: got %h expected %h (mask %h)", rsp_cnt, mon_act, mon_exp, mon_msk);
        end
      end
      n_checks++;
      if (32'(n_stack) + 32'(n_discard) + 32'(n_hand) + 32'(board_lib) + 32'(board_fas) != 17) begin
        n_fail++;
        $display("FAIL invariant_%0d: card total %0d expected 17", rsp_cnt,
                 32'(n_stack) + 32'(n_discard) + 32'(n_hand) + 32'(board_lib) + 32'(board_fas));
      end
      rsp_cnt++;
    end
  end

  // driver tasks
  task automatic issue(input logic [2:0] op, input logic [1:0] arg, input logic [RW-1:0] e,
                       input logic [RW-1:0] m, input int budget, output int l);
    int start, k;
    k = 0;
    while (!cmd_ready && k < 100) begin @(posedge clk); #1; k++; end
    l = 0;
    if (!cmd_ready) begin
      n_checks++; n_fail++;
      $display("FAIL ready_timeout: cmd_ready=0 expected 1");
      return;
    end
    cmd_op = op; cmd_arg = arg; cmd_valid = 1'b1;
    exp_q.push_back(e); msk_q.push_back(m);
    start = rsp_cnt;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    l = 1;
    while (1) begin
      @(negedge clk); #1;
      if (rsp_cnt != start) break;
      if (l >= budget) begin
        n_checks++; n_fail++;
        $display("FAIL rsp_timeout: no rsp_valid after %0d cycles, expected response for op %0d", l, op);
        exp_q.delete(); msk_q.delete();
        break;
      end
      @(posedge clk);
      l++;
    end
  endtask

  task automatic do_cmd(input logic [2:0] op, input logic [1:0] arg, input logic [RW-1:0] e, input logic [RW-1:0] m);
    int l;
    issue(op, arg, e, m, 4000, l);
  endtask

  task automatic h_draw(output int l);
    if (e_ns < 3) begin e_ns = e_ns + e_nd - 3; e_nd = 0; end
    else e_ns = e_ns - 3;
    e_nh = 3;
    issue(OP_DRAW, 2'd0, pk(1'b0, 8'd0, 5'(e_ns), 5'(e_nd), 2'(e_nh), 3'd0, 4'd0), M_BRD, 4000, l);
  endtask

  task automatic h_discard();
    e_nd++; e_nh--;
    do_cmd(OP_DISCARD, 2'd0, pk(1'b0, 8'd0, 5'(e_ns), 5'(e_nd), 2'(e_nh), 3'd0, 4'd0), M_BRD);
  endtask

  task automatic h_play();
    e_nh = 0;
    do_cmd(OP_PLAY, 2'd0, pk(1'b0, 8'd0, 5'(e_ns), 5'(e_nd), 2'(e_nh), 3'd0, 4'd0), M_D0BRD);
  endtask

  task automatic h_peek(input logic [1:0] a);
    do_cmd(OP_PEEK, a, pk(1'b0, 8'd0, 5'(e_ns), 5'(e_nd), 2'(e_nh), 3'd0, 4'd0), M_D0BRD);
  endtask

  initial begin
    rst_n = 1'b1; cmd_valid = 1'b0; cmd_op = 3'd0; cmd_arg = 2'd0; seed = 16'd0;
    #1 rst_n = 1'b0;
    #2;
    check("rst_ready", cmd_ready, 1);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_err", rsp_err, 0);
    check("rst_rsp_data", rsp_data, 0);
    check("rst_counters", {n_stack, n_discard, n_hand, board_lib, board_fas}, {5'd17, 5'd0, 2'd0, 3'd0, 4'd0});
    check("rst_deck", dut.deck, 17'h1FFC0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // draw / peek / discard / play / board from the unshuffled deck
    do_cmd(OP_DRAW,    2'd0, pk(0, 8'h00, 14, 0, 3, 0, 0), M_FULL);
    do_cmd(OP_PEEK,    2'd0, pk(0, 8'h01, 14, 0, 3, 0, 0), M_FULL);
    do_cmd(OP_PEEK,    2'd1, pk(0, 8'h01, 14, 0, 3, 0, 0), M_FULL);
    do_cmd(OP_PEEK,    2'd2, pk(0, 8'h01, 14, 0, 3, 0, 0), M_FULL);
    do_cmd(OP_DISCARD, 2'd0, pk(0, 8'h00, 14, 1, 2, 0, 0), M_FULL);
    do_cmd(OP_DISCARD, 2'd0, pk(0, 8'h00, 14, 2, 1, 0, 0), M_FULL);
    do_cmd(OP_PLAY,    2'd0, pk(0, 8'h01, 14, 2, 0, 0, 1), M_FULL);
    do_cmd(OP_BOARD,   2'd0, pk(0, 8'h10, 14, 2, 0, 0, 1), M_FULL);
    do_cmd(OP_NOP,     2'd0, pk(0, 8'h00, 14, 2, 0, 0, 1), M_FULL);

    // illegal commands leave every counter alone
    do_cmd(OP_PLAY,    2'd0, pk(1, 8'h00, 14, 2, 0, 0, 1), M_FULL);
    do_cmd(OP_PEEK,    2'd0, pk(1, 8'h00, 14, 2, 0, 0, 1), M_FULL);
    do_cmd(OP_DRAW,    2'd0, pk(0, 8'h00, 11, 2, 3, 0, 1), M_FULL);
    do_cmd(OP_DISCARD, 2'd3, pk(1, 8'h00, 11, 2, 3, 0, 1), M_FULL);
    do_cmd(OP_SHUFFLE, 2'd0, pk(1, 8'h00, 11, 2, 3, 0, 1), M_FULL);
    do_cmd(OP_DRAW,    2'd0, pk(1, 8'h00, 11, 2, 3, 0, 1), M_FULL);
    do_cmd(OP_PLAY,    2'd0, pk(1, 8'h00, 11, 2, 3, 0, 1), M_FULL);
    do_cmd(OP_DISCARD, 2'd2, pk(0, 8'h00, 11, 3, 2, 0, 1), M_FULL);
    do_cmd(OP_PEEK,    2'd2, pk(1, 8'h00, 11, 3, 2, 0, 1), M_FULL);
    do_cmd(OP_PEEK,    2'd1, pk(0, 8'h01, 11, 3, 2, 0, 1), M_FULL);

    // conservation through a seeded shuffle
    seed = 16'h1234;
    do_cmd(OP_DECK_RESET, 2'd0, pk(0, 8'h00, 17, 0, 0, 0, 0), M_FULL);
    seed = 16'h0000;
    issue(OP_SHUFFLE, 2'd0, pk(0, 8'h00, 17, 0, 0, 0, 0), M_FULL, 4000, lat);
    check("shuffle_latency_ge18", lat >= 18, 1);
    e_ns = 17; e_nd = 0; e_nh = 0; ones = 0;
    for (int k = 0; k < 5; k++) begin
      h_draw(lat);
      for (int a = 0; a < 3; a++) begin
        h_peek(2'(a));
        ones += int'(last_data[0]);
      end
      for (int a = 0; a < 3; a++) h_discard();
    end
    ones += int'(dut.deck[0]) + int'(dut.deck[1]);
    check("ones_total", ones, 11);

    // walk the deck to ns=2, nd=6 (nine cards on the board) via repeated draws
    for (int k = 0; k < 11; k++) begin
      h_draw(lat);
      h_discard();
      h_discard();
      if (k < 9) h_play();
      else       h_discard();
    end
    h_draw(lat);
    check("auto_reshuffle_latency_gt8", lat > 8, 1);

    // asynchronous reset in the middle of a shuffle
    do_cmd(OP_DECK_RESET, 2'd0, pk(0, 8'h00, 17, 0, 0, 0, 0), M_FULL);
    do_cmd(OP_DRAW,       2'd0, pk(0, 8'h00, 14, 0, 3, 0, 0), M_FULL);
    do_cmd(OP_DISCARD,    2'd0, pk(0, 8'h00, 14, 1, 2, 0, 0), M_FULL);
    do_cmd(OP_DISCARD,    2'd0, pk(0, 8'h00, 14, 2, 1, 0, 0), M_FULL);
    do_cmd(OP_PLAY,       2'd0, pk(0, 8'h01, 14, 2, 0, 0, 1), M_FULL);
    w = 0;
    while (!cmd_ready && w < 100) begin @(posedge clk); #1; w++; end
    cmd_op = OP_SHUFFLE; cmd_arg = 2'd0; cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    w = 0;
    while (dbg_state != ST_FY && w < 50) begin @(posedge clk); #1; w++; end
    check("reached_fy", dbg_state, ST_FY);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    check("abort_state", dbg_state, ST_IDLE);
    check("abort_counters", {n_stack, n_discard, n_hand, board_lib, board_fas}, {5'd17, 5'd0, 2'd0, 3'd0, 4'd0});
    check("abort_deck", dut.deck, 17'h1FFC0);
    check("abort_rsp_valid", rsp_valid, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("post_abort_ready", cmd_ready, 1);
    check("post_abort_rsp_valid", rsp_valid, 0);
    repeat (20) @(posedge clk);
    #1;
    do_cmd(OP_NOP, 2'd0, pk(0, 8'h00, 17, 0, 0, 0, 0), M_FULL);

    check("queue_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
